// File: rtl/alu_seq_if.sv
// Request/response bundle between execute-stage control and the sequential ALU.
// Control drives the request side (master); the ALU drives results and status (slave).
interface alu_seq_if #(
  parameter int unsigned N = 16
);
  logic         start;
  logic [3:0]   ALU_op;
  logic [N-1:0] Reg_read_data_1;
  logic [N-1:0] MUX_3_out;
  logic [N-1:0] ALU_result;
  logic [N-1:0] ALU_result_hi;
  logic         zero;
  logic         overflow;
  logic         busy;
  logic         done;

  modport master (
    output start, ALU_op, Reg_read_data_1, MUX_3_out,
    input  ALU_result, ALU_result_hi, zero, overflow, busy, done
  );

  modport slave (
    input  start, ALU_op, Reg_read_data_1, MUX_3_out,
    output ALU_result, ALU_result_hi, zero, overflow, busy, done
  );
endinterface

// File: rtl/alu_seq_unit.sv
// Execute-stage ALU: single-cycle logic/arith ops plus sequential unsigned
// shift-add multiply and restoring divide behind a start/busy/done handshake.
module alu_seq_unit #(
  parameter int unsigned N = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_seq_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(N);
  localparam int unsigned ACC_W = 2 * N;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_SLT = 4'b1000;
  localparam logic [3:0] OP_MUL = 4'b1001;
  localparam logic [3:0] OP_DIV = 4'b1010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // MUL: opa = multiplicand (shifts left), opb = multiplier (shifts right), acc = product.
  // DIV: opa low half = divisor, opb = dividend shifting into quotient, acc low half = remainder.
  logic [ACC_W-1:0] opa_q, opa_d;
  logic [N-1:0]     opb_q, opb_d;
  logic [ACC_W-1:0] acc_q, acc_d;

  logic [N-1:0]     result_q, result_d;
  logic [N-1:0]     result_hi_q, result_hi_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [N-1:0]     op_a, op_b;
  logic [CNT_W-1:0] shamt;
  logic [N-1:0]     add_r, sub_r;
  logic [N-1:0]     alu_r;
  logic             alu_ovf;

  logic [ACC_W-1:0] mul_acc;
  logic [N:0]       div_part;
  logic             div_ge;
  logic [N-1:0]     div_rem;
  logic [N-1:0]     div_quo;
  logic             last_iter;

  assign op_a  = bus.Reg_read_data_1;
  assign op_b  = bus.MUX_3_out;
  assign shamt = op_b[CNT_W-1:0];
  assign add_r = op_a + op_b;
  assign sub_r = op_a - op_b;

  // Single-cycle datapath, evaluated on the live operands
  always_comb begin
    alu_r   = '0;
    alu_ovf = 1'b0;
    case (bus.ALU_op)
      OP_ADD: begin
        alu_r   = add_r;
        alu_ovf = (op_a[N-1] == op_b[N-1]) && (add_r[N-1] != op_a[N-1]);
      end
      OP_SUB: begin
        alu_r   = sub_r;
        alu_ovf = (op_a[N-1] != op_b[N-1]) && (sub_r[N-1] != op_a[N-1]);
      end
      OP_AND:  alu_r = op_a & op_b;
      OP_OR:   alu_r = op_a | op_b;
      OP_XOR:  alu_r = op_a ^ op_b;
      OP_SLL:  alu_r = op_a << shamt;
      OP_SRL:  alu_r = op_a >> shamt;
      OP_SRA:  alu_r = N'($signed(op_a) >>> shamt);
      OP_SLT:  alu_r = {{(N-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      default: alu_r = '0;
    endcase
  end

  // One iteration of each sequential algorithm
  always_comb begin
    mul_acc   = opb_q[0] ? (acc_q + opa_q) : acc_q;
    div_part  = {acc_q[N-1:0], opb_q[N-1]};
    div_ge    = div_part >= {1'b0, opa_q[N-1:0]};
    div_rem   = div_ge ? N'(div_part - {1'b0, opa_q[N-1:0]}) : div_part[N-1:0];
    div_quo   = {opb_q[N-2:0], div_ge};
    last_iter = (cnt_q == CNT_W'(N - 1));
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    acc_d       = acc_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.ALU_op == OP_MUL) begin
            state_d = S_MUL;
            cnt_d   = '0;
            acc_d   = '0;
            opa_d   = ACC_W'(op_a);
            opb_d   = op_b;
            busy_d  = 1'b1;
          end else if (bus.ALU_op == OP_DIV && op_b != '0) begin
            state_d = S_DIV;
            cnt_d   = '0;
            acc_d   = '0;
            opa_d   = ACC_W'(op_b);
            opb_d   = op_a;
            busy_d  = 1'b1;
          end else if (bus.ALU_op == OP_DIV) begin
            // Divide by zero resolves immediately: all-ones quotient, dividend as remainder
            result_d    = '1;
            result_hi_d = op_a;
            zero_d      = 1'b0;
            ovf_d       = 1'b0;
            done_d      = 1'b1;
          end else begin
            result_d    = alu_r;
            result_hi_d = '0;
            zero_d      = (alu_r == '0);
            ovf_d       = alu_ovf;
            done_d      = 1'b1;
          end
        end
      end

      S_MUL: begin
        acc_d = mul_acc;
        opa_d = opa_q << 1;
        opb_d = opb_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter) begin
          state_d     = S_IDLE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          result_d    = mul_acc[N-1:0];
          result_hi_d = mul_acc[ACC_W-1:N];
          zero_d      = (mul_acc[N-1:0] == '0);
          ovf_d       = 1'b0;
        end
      end

      S_DIV: begin
        acc_d = ACC_W'(div_rem);
        opb_d = div_quo;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter) begin
          state_d     = S_IDLE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          result_d    = div_quo;
          result_hi_d = div_rem;
          zero_d      = (div_quo == '0);
          ovf_d       = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any in-flight operation
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.ALU_result    = result_q;
  assign bus.ALU_result_hi = result_hi_q;
  assign bus.zero          = zero_q;
  assign bus.overflow      = ovf_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Scoreboard bench for alu_seq_unit: directed vectors push expected responses,
// an independent monitor pops and compares on every done pulse.
module tb_alu_seq_unit;

  localparam int unsigned N = 16;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_SLT = 4'b1000;
  localparam logic [3:0] OP_MUL = 4'b1001;
  localparam logic [3:0] OP_DIV = 4'b1010;
  localparam logic [3:0] OP_RSV = 4'b1111;

  typedef struct {
    string       nm;
    logic [15:0] r;
    logic [15:0] hi;
    logic        z;
    logic        o;
    int          lat;
    int          bsy;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   busy_run = 0;
  exp_t sb[$];

  alu_seq_if #(.N(N)) bus ();

  alu_seq_unit #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Call at a negedge; waits out busy, presents the request, pushes its expectation
  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] er, input logic [15:0] ehi,
                       input logic ez, input logic eo, input string nm);
    exp_t e;
    int   guard;
    bit   multi;
    guard = 0;
    while (bus.busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s.busy_timeout: got busy=1 expected busy=0 within 100 cycles", nm);
    end
    bus.start           = 1'b1;
    bus.ALU_op          = op;
    bus.Reg_read_data_1 = a;
    bus.MUX_3_out       = b;
    multi  = (op == OP_MUL) || (op == OP_DIV && b != 16'h0);
    e.nm   = nm;
    e.r    = er;
    e.hi   = ehi;
    e.z    = ez;
    e.o    = eo;
    e.lat  = multi ? N : 0;
    e.bsy  = multi ? N : 0;
    e.acc  = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() > 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    while (sb.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s.no_done: got no done expected done within 100 cycles", sb[0].nm);
      void'(sb.pop_front());
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        busy_run = 0;
        continue;
      end
      check("busy_done_exclusive", 32'(bus.busy & bus.done), 32'd0);
      if (bus.busy) busy_run++;
      if (bus.done) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected done=0 (result 0x%0h)", bus.ALU_result);
        end else begin
          e = sb.pop_front();
          check({e.nm, ".result"},   32'(bus.ALU_result),    32'(e.r));
          check({e.nm, ".result_hi"}, 32'(bus.ALU_result_hi), 32'(e.hi));
          check({e.nm, ".zero"},     32'(bus.zero),          32'(e.z));
          check({e.nm, ".overflow"}, 32'(bus.overflow),      32'(e.o));
          check({e.nm, ".latency"},  32'(cyc - e.acc),       32'(e.lat));
          check({e.nm, ".busy_cycles"}, 32'(busy_run),       32'(e.bsy));
        end
        busy_run = 0;
      end
    end
  end

  // Stimulus
  initial begin
    bus.start           = 1'b1;
    bus.ALU_op          = OP_ADD;
    bus.Reg_read_data_1 = 16'd10;
    bus.MUX_3_out       = 16'd20;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.result",    32'(bus.ALU_result),    32'd0);
    check("reset.result_hi", 32'(bus.ALU_result_hi), 32'd0);
    check("reset.zero",      32'(bus.zero),          32'd0);
    check("reset.overflow",  32'(bus.overflow),      32'd0);
    check("reset.busy",      32'(bus.busy),          32'd0);
    check("reset.done",      32'(bus.done),          32'd0);
    rst_n = 1'b1;

    issue(OP_ADD, 16'd10,   16'd20,   16'd30,   16'h0, 1'b0, 1'b0, "add_10_20");
    issue(OP_SUB, 16'd10,   16'd20,   16'hFFF6, 16'h0, 1'b0, 1'b0, "sub_10_20");
    issue(OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 16'h0, 1'b0, 1'b1, "add_ovf");
    issue(OP_SUB, 16'd5,    16'd5,    16'h0000, 16'h0, 1'b1, 1'b0, "sub_zero");
    issue(OP_SRA, 16'h8000, 16'd3,    16'hF000, 16'h0, 1'b0, 1'b0, "sra");
    issue(OP_SLT, 16'hFFFF, 16'h0001, 16'h0001, 16'h0, 1'b0, 1'b0, "slt_neg");
    issue(OP_SLT, 16'h0001, 16'hFFFF, 16'h0000, 16'h0, 1'b1, 1'b0, "slt_pos");
    issue(OP_AND, 16'hF0F0, 16'h0FF0, 16'h00F0, 16'h0, 1'b0, 1'b0, "and");
    issue(OP_OR,  16'hF000, 16'h000F, 16'hF00F, 16'h0, 1'b0, 1'b0, "or");
    issue(OP_XOR, 16'hFFFF, 16'h0F0F, 16'hF0F0, 16'h0, 1'b0, 1'b0, "xor");
    issue(OP_SLL, 16'h0001, 16'h0014, 16'h0010, 16'h0, 1'b0, 1'b0, "sll_masked");
    issue(OP_SRL, 16'h8000, 16'h000F, 16'h0001, 16'h0, 1'b0, 1'b0, "srl");
    issue(OP_RSV, 16'h1234, 16'h5678, 16'h0000, 16'h0, 1'b1, 1'b0, "reserved_op");
    issue(OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 16'h0, 1'b1, 1'b0, "add_wrap");
    issue(OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 16'h0, 1'b0, 1'b1, "sub_ovf");

    issue(OP_MUL, 16'd300,  16'd300,  16'h5F90, 16'h0001, 1'b0, 1'b0, "mul_300");
    // Operand churn and a stray start while busy must not disturb the multiply
    for (int i = 0; i < 4; i++) begin
      bus.ALU_op          = 4'(i);
      bus.Reg_read_data_1 = 16'($urandom);
      bus.MUX_3_out       = 16'($urandom);
      @(negedge clk);
    end
    bus.start           = 1'b1;
    bus.ALU_op          = OP_ADD;
    bus.Reg_read_data_1 = 16'd1;
    bus.MUX_3_out       = 16'd1;
    @(negedge clk);
    bus.start = 1'b0;

    issue(OP_ADD, 16'd2,    16'd3,    16'd5,    16'h0,    1'b0, 1'b0, "add_after_mul");
    issue(OP_DIV, 16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 1'b0, "div_100_7");
    issue(OP_DIV, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b0, 1'b0, "div_by_zero");
    issue(OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 1'b0, "mul_max");
    issue(OP_DIV, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b0, "div_by_one");
    issue(OP_DIV, 16'd7,    16'd100,  16'h0000, 16'd7,    1'b1, 1'b0, "div_small");
    drain();

    // Reset five cycles into a multiply: aborted, no done
    bus.start           = 1'b1;
    bus.ALU_op          = OP_MUL;
    bus.Reg_read_data_1 = 16'd300;
    bus.MUX_3_out       = 16'd300;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("midmul.busy_before_reset", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midmul_reset.busy",      32'(bus.busy),          32'd0);
    check("midmul_reset.done",      32'(bus.done),          32'd0);
    check("midmul_reset.result",    32'(bus.ALU_result),    32'd0);
    check("midmul_reset.result_hi", 32'(bus.ALU_result_hi), 32'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    issue(OP_ADD, 16'd2,    16'd3,    16'd5,    16'h0,    1'b0, 1'b0, "add_after_reset");
    drain();
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
